// File: rtl/dma_pkg.sv
// Shared definitions for the byte-copy DMA controller.
//   DMA_D       : default address/data width of the data memory port
//   dma_state_e : controller state encoding
package dma_pkg;

   localparam int DMA_D = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } dma_state_e;

endpackage

// File: rtl/dma_port_mux.sv
// Data memory port arbiter (combinational).
// The core always owns the port unless the grant is up. With the grant, the
// DMA drives the port in READ and WRITE.
// Ports:
//   i_grant                : DMA owns the port this cycle
//   i_state                : current controller state
//   i_src_ptr / i_dst_ptr  : DMA read / write addresses
//   i_buf                  : byte captured by the last DMA read
//   i_cpu_*                : core request signals
//   o_mem_*                : drive to dat_mem
module dma_port_mux
   import dma_pkg::*;
#(
   parameter int D = DMA_D
) (
   input  logic         i_grant,
   input  logic [1:0]   i_state,
   input  logic [D-1:0] i_src_ptr,
   input  logic [D-1:0] i_dst_ptr,
   input  logic [D-1:0] i_buf,
   input  logic         i_cpu_mem_write,
   input  logic [D-1:0] i_cpu_addr,
   input  logic [D-1:0] i_cpu_data_in,
   output logic [D-1:0] o_mem_addr,
   output logic         o_mem_write_en,
   output logic [D-1:0] o_mem_data_in
);

   always_comb begin
      o_mem_addr     = i_cpu_addr;
      o_mem_data_in  = i_cpu_data_in;
      o_mem_write_en = i_cpu_mem_write;
      if (i_grant) begin
         if (i_state == 2'(READ)) begin
            o_mem_addr     = i_src_ptr;
            o_mem_write_en = 1'b0;
         end else if (i_state == 2'(WRITE)) begin
            o_mem_addr     = i_dst_ptr;
            o_mem_data_in  = i_buf;
            o_mem_write_en = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_ctrl.sv
// Byte-copy DMA controller sharing a single-port data memory with the core.
// The core has priority: the DMA only advances in cycles with no core access.
// Each byte takes one READ cycle (capture into buf) and one WRITE cycle.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for i_start; core owns the memory port
//   READ  | fetch byte at src_ptr into buf when granted
//   WRITE | store buf at dst_ptr when granted, advance pointers/count
//   DONE  | single-cycle completion pulse on o_done
//
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start                 : copy request (sampled in IDLE only)
//   i_src_addr, i_dst_addr  : first source / destination byte address
//   i_len                   : byte count, 0 completes without memory access
//   i_cpu_mem_read/_write   : core memory requests
//   i_cpu_addr, i_cpu_data_in : core address / write data
//   i_mem_data_out          : combinational read data from dat_mem
//   o_mem_addr, o_mem_write_en, o_mem_data_in : drive to dat_mem
//   o_busy                  : high in READ and WRITE
//   o_done                  : one-cycle pulse in DONE
module dma_ctrl
   import dma_pkg::*;
#(
   parameter int D = DMA_D
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [D-1:0] i_src_addr,
   input  logic [D-1:0] i_dst_addr,
   input  logic [D-1:0] i_len,
   input  logic         i_cpu_mem_read,
   input  logic         i_cpu_mem_write,
   input  logic [D-1:0] i_cpu_addr,
   input  logic [D-1:0] i_cpu_data_in,
   input  logic [D-1:0] i_mem_data_out,
   output logic [D-1:0] o_mem_addr,
   output logic         o_mem_write_en,
   output logic [D-1:0] o_mem_data_in,
   output logic         o_busy,
   output logic         o_done
);

   dma_state_e   r_state;
   logic [D-1:0] r_src_ptr;
   logic [D-1:0] r_dst_ptr;
   logic [D-1:0] r_count;
   logic [D-1:0] r_buf;
   logic         r_busy;
   logic         r_done;

   logic         w_grant;
   logic         w_port_grant;

   assign w_grant = ~i_cpu_mem_read & ~i_cpu_mem_write;
   // While reset is held the port must already be back with the core, so the
   // DMA cannot issue a write in the cycle that aborts a copy.
   assign w_port_grant = w_grant & ~i_reset;

   assign o_busy = r_busy & ~i_reset;
   assign o_done = r_done & ~i_reset;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_src_ptr <= '0;
         r_dst_ptr <= '0;
         r_count   <= '0;
         r_buf     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  if (i_len != '0) begin
                     r_src_ptr <= i_src_addr;
                     r_dst_ptr <= i_dst_addr;
                     r_count   <= i_len;
                     r_busy    <= 1'b1;
                     r_state   <= READ;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            READ: begin
               if (w_grant) begin
                  r_buf   <= i_mem_data_out;
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               if (w_grant) begin
                  r_src_ptr <= r_src_ptr + D'(1);
                  r_dst_ptr <= r_dst_ptr + D'(1);
                  if (r_count != '0) begin
                     r_count <= r_count - D'(1);
                  end
                  // count of 0 cannot occur here; treat it as last byte anyway
                  if (r_count <= D'(1)) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= READ;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   dma_port_mux #(
      .D (D)
   ) u_port_mux (
      .i_grant         (w_port_grant),
      .i_state         (r_state),
      .i_src_ptr       (r_src_ptr),
      .i_dst_ptr       (r_dst_ptr),
      .i_buf           (r_buf),
      .i_cpu_mem_write (i_cpu_mem_write),
      .i_cpu_addr      (i_cpu_addr),
      .i_cpu_data_in   (i_cpu_data_in),
      .o_mem_addr      (o_mem_addr),
      .o_mem_write_en  (o_mem_write_en),
      .o_mem_data_in   (o_mem_data_in)
   );

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: a 256-byte dat_mem model behind the DUT port, a
// reference memory image kept by the bench, and a queue of expected DMA
// writes that a monitor pops whenever the DUT writes on its own behalf.
module tb_dma_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] src_addr;
   logic [7:0] dst_addr;
   logic [7:0] len;
   logic       cpu_rd;
   logic       cpu_wr;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_din;
   logic [7:0] mem_rdata;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic       busy;
   logic       done;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   logic [15:0] exp_q   [$];

   int n_checks = 0;
   int n_fails  = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   dma_ctrl #(.D(8)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_start         (start),
      .i_src_addr      (src_addr),
      .i_dst_addr      (dst_addr),
      .i_len           (len),
      .i_cpu_mem_read  (cpu_rd),
      .i_cpu_mem_write (cpu_wr),
      .i_cpu_addr      (cpu_addr),
      .i_cpu_data_in   (cpu_din),
      .i_mem_data_out  (mem_rdata),
      .o_mem_addr      (mem_addr),
      .o_mem_write_en  (mem_we),
      .o_mem_data_in   (mem_wdata),
      .o_busy          (busy),
      .o_done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // DMA-originated writes are those with the port write enable up while the
   // core is not writing.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst) begin
         if (mem_we && !cpu_wr) begin
            if (exp_q.size() == 0) begin
               check_val("dma_wr_extra_qsize", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check_val("dma_wr_addr", mem_addr, e[15:8]);
               check_val("dma_wr_data", mem_wdata, e[7:0]);
            end
         end
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      cpu_wr   = 1'b1;
      cpu_addr = a;
      cpu_din  = d;
      ref_mem[a] = d;
      @(posedge clk); #1;
      cpu_wr = 1'b0;
   endtask

   // Queue the first n_wr byte moves of a forward copy, then pulse start.
   task automatic start_copy(input logic [7:0] s, input logic [7:0] d,
                             input logic [7:0] l, input int n_wr);
      logic [7:0] sa;
      logic [7:0] da;
      for (int i = 0; i < n_wr; i++) begin
         sa = s + 8'(i);
         da = d + 8'(i);
         ref_mem[da] = ref_mem[sa];
         exp_q.push_back({da, ref_mem[sa]});
      end
      src_addr = s;
      dst_addr = d;
      len      = l;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int cpu_n, input bit restart, input int exp_cyc,
                            input bit exp_busy, input string tag);
      int cyc;
      cyc = 0;
      while (!done && cyc < 200) begin
         if (exp_busy && cyc == 1) check_val({tag, "_busy"}, busy, 1);
         cpu_wr   = (cpu_n > 0 && cyc >= 2 && cyc < 2 + cpu_n);
         cpu_addr = 8'h80;
         cpu_din  = 8'h5A;
         start    = restart && (cyc == 2);
         if (restart && cyc == 2) begin
            src_addr = 8'hFE;
            dst_addr = 8'hA0;
            len      = 8'd2;
         end
         @(posedge clk); #1;
         cyc++;
      end
      cpu_wr = 1'b0;
      start  = 1'b0;
      if (cpu_n > 0) ref_mem[8'h80] = 8'h5A;
      check_val({tag, "_latency"}, cyc, exp_cyc);
      @(posedge clk); #1;
      check_val({tag, "_done_pulse"}, done, 0);
      check_val({tag, "_busy_after"}, busy, 0);
      check_val({tag, "_q_drained"}, exp_q.size(), 0);
   endtask

   task automatic check_mem(input logic [7:0] a, input string tag);
      check_val(tag, mem[a], ref_mem[a]);
   endtask

   initial begin
      int b0;
      int d0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;

      // reset: outputs idle and the port follows the core
      @(posedge clk); #1;
      cpu_wr = 1'b1; cpu_addr = 8'h55; cpu_din = 8'h33;
      #1;
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_pt_addr", mem_addr, 8'h55);
      check_val("rst_pt_we", mem_we, 1);
      check_val("rst_pt_data", mem_wdata, 8'h33);
      ref_mem[8'h55] = 8'h33;
      @(posedge clk); #1;
      cpu_wr = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // basic 4-byte copy
      cpu_write(8'h10, 8'h11); cpu_write(8'h11, 8'h22);
      cpu_write(8'h12, 8'h33); cpu_write(8'h13, 8'h44);
      start_copy(8'h10, 8'h40, 8'd4, 4);
      wait_done(0, 1'b0, 8, 1'b1, "basic");
      for (int i = 0; i < 4; i++) check_mem(8'h40 + 8'(i), "basic_mem");

      // same copy with three core-write cycles stealing the port
      start_copy(8'h10, 8'h60, 8'd4, 4);
      wait_done(3, 1'b0, 11, 1'b1, "cpu_steal");
      for (int i = 0; i < 4; i++) check_mem(8'h60 + 8'(i), "cpu_steal_mem");
      check_mem(8'h80, "cpu_steal_cpu_byte");

      // zero length: done right away, never busy, no DMA writes
      b0 = busy_cnt;
      start_copy(8'h10, 8'hB0, 8'd0, 0);
      wait_done(0, 1'b0, 0, 1'b0, "len0");
      check_val("len0_busy_cycles", busy_cnt - b0, 0);

      // source wraps past 0xFF
      cpu_write(8'hFE, 8'hA1); cpu_write(8'hFF, 8'hA2); cpu_write(8'h00, 8'hA3);
      start_copy(8'hFE, 8'h20, 8'd3, 3);
      wait_done(0, 1'b0, 6, 1'b1, "wrap");
      for (int i = 0; i < 3; i++) check_mem(8'h20 + 8'(i), "wrap_mem");

      // reset after two bytes of a four-byte copy
      for (int i = 0; i < 4; i++) begin
         cpu_write(8'h30 + 8'(i), 8'(i + 1));
         cpu_write(8'h70 + 8'(i), 8'hEE);
      end
      d0 = done_cnt;
      start_copy(8'h30, 8'h70, 8'd4, 2);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check_val("abort_busy_in_rst", busy, 0);
      check_val("abort_we_in_rst", mem_we, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check_val("abort_busy", busy, 0);
      check_val("abort_no_done", done_cnt - d0, 0);
      check_val("abort_q_drained", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) check_mem(8'h70 + 8'(i), "abort_mem");

      // second start while busy is ignored
      cpu_write(8'hA0, 8'hCC); cpu_write(8'hA1, 8'hCC);
      start_copy(8'h10, 8'h90, 8'd4, 4);
      wait_done(0, 1'b1, 8, 1'b1, "restart");
      for (int i = 0; i < 4; i++) check_mem(8'h90 + 8'(i), "restart_mem");
      check_mem(8'hA0, "restart_other_dst0");
      check_mem(8'hA1, "restart_other_dst1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter D, default 8: data memory address and data width.
REQ-002 Clk  in  1  system clock; all state changes on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Start  in  1  copy request; sampled only in IDLE.
REQ-005 SrcAddr  in  D  first source byte address.
REQ-006 DstAddr  in  D  first destination byte address.
REQ-007 Len  in  D  byte count; 0 is a no-op.
REQ-008 CpuMemRead  in  1  core data memory read request.
REQ-009 CpuMemWrite  in  1  core data memory write request.
REQ-010 CpuAddr  in  D  core memory address.
REQ-011 CpuDataIn  in  D  core write data.
REQ-012 MemDataOut  in  D  combinational read data from dat_mem.
REQ-013 MemAddr  out  D  address to dat_mem.
REQ-014 MemWriteEn  out  1  write enable to dat_mem.
REQ-015 MemDataIn  out  D  write data to dat_mem.
REQ-016 Busy  out  1  high in READ and WRITE.
REQ-017 Done  out  1  one-cycle pulse in DONE.

Function
REQ-018 FSM states IDLE, READ, WRITE, DONE; exactly one state is active each cycle.
REQ-019 IDLE with Start=1 and Len!=0 latches SrcAddr, DstAddr and Len into src_ptr, dst_ptr and count, then goes to READ.
REQ-020 IDLE with Start=1 and Len=0 goes directly to DONE; memory is not accessed.
REQ-021 Start is ignored in READ, WRITE and DONE; latched parameters do not change.
REQ-022 Core priority: the DMA is granted only in cycles where CpuMemRead=0 and CpuMemWrite=0.
REQ-023 When not granted: MemAddr=CpuAddr, MemDataIn=CpuDataIn, MemWriteEn=CpuMemWrite, and the FSM holds its state.
REQ-024 READ, granted: MemAddr=src_ptr, MemWriteEn=0; MemDataOut is captured into buf at the edge and the FSM goes to WRITE.
REQ-025 WRITE, granted: MemAddr=dst_ptr, MemDataIn=buf, MemWriteEn=1.
REQ-026 At the same WRITE edge, src_ptr and dst_ptr increment and count decrements.
REQ-027 After the WRITE edge, the FSM goes to DONE if count was 1, otherwise to READ.
REQ-028 Pointers wrap modulo 2^D (0xFF+1=0x00); count never underflows.
REQ-029 Bytes are copied in ascending order, one at a time, so overlapping regions give forward-copy semantics.
REQ-030 DONE lasts exactly one cycle with Done=1, then goes to IDLE.
REQ-031 Latency with no core traffic: Start edge to Done high is 2*Len cycles; each core-access cycle adds one cycle.
REQ-032 In IDLE and DONE the memory port passes core signals through as in REQ-023.

Reset
REQ-033 Reset=1 at an edge forces IDLE and sets src_ptr, dst_ptr, count and buf to 0.
REQ-034 Outputs during and after reset: Busy=0, Done=0, and core pass-through.
REQ-035 Reset mid-copy aborts the copy with no further DMA write and no Done pulse; bytes already written remain.

Structure
REQ-036 Shared package dma_pkg holds the state enum (IDLE/READ/WRITE/DONE) and the width constant D.
REQ-037 Sub-module dma_port_mux (combinational) selects core or DMA drive of MemAddr, MemWriteEn and MemDataIn from the grant and state.

Verification
REQ-038 Mem[0x10..0x13]=11,22,33,44; Start, Src=0x10, Dst=0x40, Len=4, no core traffic -> Mem[0x40..0x43]=11,22,33,44 and Done high exactly 8 cycles after the Start edge.
REQ-039 Same copy with CpuMemWrite=1 (Addr 0x80, Data 0x5A) for 3 cycles during the copy -> Mem[0x80]=0x5A, copy still correct, Done delayed 3 cycles.
REQ-040 Start with Len=0 -> Done the next cycle, Busy never high, no MemWriteEn from the DMA.
REQ-041 Src=0xFE, Dst=0x20, Len=3 -> Mem[0xFE], Mem[0xFF], Mem[0x00] copied to 0x20..0x22.
REQ-042 Reset asserted after 2 bytes of a Len=4 copy -> only 2 destination bytes change, no Done, IDLE with Busy=0.
REQ-043 Start pulsed again while Busy, with different parameters -> ignored, and the original copy completes unchanged.
